// File: rtl/spi_burst_sequencer.sv
// Multi-byte SPI burst sequencer: walks TX buffer bytes 0..N through the byte engine,
// stores each received byte in the RX buffer and keeps chip select low for the burst.
module spi_burst_sequencer #(
    parameter int ADDR_W   = 9,
    parameter int CS_SETUP = 2,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_we_i,
    input  logic [31:0]       cmd_i,
    output logic [31:0]       status_o,
    output logic [ADDR_W-1:0] txbuf_addr_o,
    input  logic [7:0]        txbuf_rdata_i,
    output logic              rxbuf_we_o,
    output logic [ADDR_W-1:0] rxbuf_addr_o,
    output logic [7:0]        rxbuf_wdata_o,
    output logic              spi_start_o,
    output logic [7:0]        spi_tx_data_o,
    input  logic              spi_done_i,
    input  logic [7:0]        spi_rx_data_i,
    output logic              cs_n_o,
    output logic              done_o
);

    localparam int CNT_MAX = (TIMEOUT > CS_SETUP) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                                  : ((CS_SETUP > GAP) ? CS_SETUP : GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_FETCH, S_RDWAIT, S_LAUNCH, S_WAIT, S_STORE, S_GAP, S_FINISH
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_idx, r_last, r_tx_addr, r_rx_addr;
    logic [ADDR_W:0]    r_rx_count;
    logic               r_all1, r_all0, r_busy, r_err;
    logic [7:0]         r_rx_byte, r_rx_wdata, r_tx_data;
    logic               r_start, r_we, r_done, r_cs_n;
    logic               w_send, w_abort, w_timeout, w_unused;
    logic [31:0]        w_status;

    function automatic logic [7:0] pick_tx(input logic all1, input logic all0,
                                           input logic [7:0] ram_byte);
        logic [7:0] sel;
        if (all1) begin
            sel = 8'hFF;
        end else if (all0) begin
            sel = 8'h00;
        end else begin
            sel = ram_byte;
        end
        return sel;
    endfunction

    assign w_send    = cmd_we_i && cmd_i[0] && (r_state == S_IDLE);
    assign w_abort   = cmd_we_i && cmd_i[1] && r_busy;
    assign w_timeout = (r_state == S_WAIT) && !spi_done_i && !w_abort
                       && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused  = ^cmd_i[31:4+ADDR_W];

    // Next-state decode; an abort overrides every busy state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_send) w_state_nxt = S_SETUP; else w_state_nxt = S_IDLE;
                S_SETUP:  if (r_cnt == CNT_W'(CS_SETUP - 1)) w_state_nxt = S_FETCH;
                          else w_state_nxt = S_SETUP;
                S_FETCH:  w_state_nxt = S_RDWAIT;
                S_RDWAIT: w_state_nxt = S_LAUNCH;
                S_LAUNCH: w_state_nxt = S_WAIT;
                S_WAIT:   if (spi_done_i) w_state_nxt = S_STORE;
                          else if (r_cnt == CNT_W'(TIMEOUT - 1)) w_state_nxt = S_IDLE;
                          else w_state_nxt = S_WAIT;
                S_STORE:  if (r_idx == r_last) w_state_nxt = S_FINISH; else w_state_nxt = S_GAP;
                S_GAP:    if (r_cnt == CNT_W'(GAP - 1)) w_state_nxt = S_FETCH;
                          else w_state_nxt = S_GAP;
                S_FINISH: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, shared cycle counter and registered strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_cs_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state != w_state_nxt) ? '0 : r_cnt + CNT_W'(1);
            r_start <= (r_state == S_LAUNCH) && !w_abort;
            r_we    <= (r_state == S_STORE) && !w_abort;
            r_done  <= (w_state_nxt == S_FINISH);
            r_cs_n  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FINISH);
        end
    end

    // Burst datapath and status fields; status holds after the burst ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx      <= '0;
            r_last     <= '0;
            r_all1     <= 1'b0;
            r_all0     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rx_count <= '0;
            r_tx_addr  <= '0;
            r_rx_addr  <= '0;
            r_rx_byte  <= 8'h00;
            r_rx_wdata <= 8'h00;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_send) begin
                        r_all1     <= cmd_i[2];
                        r_all0     <= cmd_i[3];
                        r_last     <= cmd_i[4 +: ADDR_W];
                        r_idx      <= '0;
                        r_rx_count <= '0;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                    end
                end
                S_FETCH:  r_tx_addr <= r_idx;
                S_LAUNCH: r_tx_data <= pick_tx(r_all1, r_all0, txbuf_rdata_i);
                S_WAIT: begin
                    if (spi_done_i) begin
                        r_rx_byte <= spi_rx_data_i;
                    end
                end
                S_STORE: begin
                    if (!w_abort) begin
                        r_rx_addr  <= r_idx;
                        r_rx_wdata <= r_rx_byte;
                        r_rx_count <= {1'b0, r_idx} + (ADDR_W + 1)'(1);
                        if (r_idx != r_last) begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if ((w_state_nxt == S_FINISH) || (w_abort) || (w_timeout)) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status        = 32'h0000_0000;
        w_status[0]     = r_busy;
        w_status[1]     = r_err;
        w_status[2]     = r_all1;
        w_status[3]     = r_all0;
        w_status[12:4]  = 9'(r_last);
        w_status[25:16] = 10'(r_rx_count);
    end

    assign status_o      = w_status;
    assign txbuf_addr_o  = r_tx_addr;
    assign rxbuf_we_o    = r_we;
    assign rxbuf_addr_o  = r_rx_addr;
    assign rxbuf_wdata_o = r_rx_wdata;
    assign spi_start_o   = r_start;
    assign spi_tx_data_o = r_tx_data;
    assign cs_n_o        = r_cs_n;
    assign done_o        = r_done;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with TX/RX RAM models and an echoing byte engine.
module tb_spi_burst_sequencer;

    localparam int ADDR_W  = 9;
    localparam int ENG_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              cmd_we_i;
    logic [31:0]       cmd_i;
    logic [31:0]       status_o;
    logic [ADDR_W-1:0] txbuf_addr_o;
    logic [7:0]        txbuf_rdata_i;
    logic              rxbuf_we_o;
    logic [ADDR_W-1:0] rxbuf_addr_o;
    logic [7:0]        rxbuf_wdata_o;
    logic              spi_start_o;
    logic [7:0]        spi_tx_data_o;
    logic              spi_done_i;
    logic [7:0]        spi_rx_data_i;
    logic              cs_n_o;
    logic              done_o;

    logic [7:0] tx_mem [0:511];
    logic [7:0] rx_mem [0:511];
    int  checks = 0, failures = 0;
    int  we_cnt = 0, start_cnt = 0, done_cnt = 0, cs_glitch = 0;
    logic       eng_en;
    logic [7:0] last_tx;

    spi_burst_sequencer dut (
        .clk_i(clk), .rst_ni(rst_ni), .cmd_we_i(cmd_we_i), .cmd_i(cmd_i),
        .status_o(status_o), .txbuf_addr_o(txbuf_addr_o), .txbuf_rdata_i(txbuf_rdata_i),
        .rxbuf_we_o(rxbuf_we_o), .rxbuf_addr_o(rxbuf_addr_o), .rxbuf_wdata_o(rxbuf_wdata_o),
        .spi_start_o(spi_start_o), .spi_tx_data_o(spi_tx_data_o), .spi_done_i(spi_done_i),
        .spi_rx_data_i(spi_rx_data_i), .cs_n_o(cs_n_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // TX RAM: one cycle read latency
    always @(posedge clk) txbuf_rdata_i <= tx_mem[txbuf_addr_o];

    always @(negedge clk) begin
        if (rxbuf_we_o) begin
            rx_mem[rxbuf_addr_o] = rxbuf_wdata_o;
            we_cnt++;
        end
        if (spi_start_o) start_cnt++;
        if (done_o) done_cnt++;
        if (status_o[0] && cs_n_o) cs_glitch++;
    end

    // Echo engine: returns the sent byte ENG_LAT cycles after start
    always begin
        logic [7:0] b;
        @(negedge clk);
        if (eng_en && spi_start_o) begin
            b = spi_tx_data_o;
            last_tx = b;
            repeat (ENG_LAT) @(negedge clk);
            spi_done_i    = 1'b1;
            spi_rx_data_i = b;
            @(negedge clk);
            spi_done_i    = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] v);
        cmd_we_i = 1'b1;
        cmd_i    = v;
        @(negedge clk);
        cmd_we_i = 1'b0;
        cmd_i    = 32'h0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (status_o[0] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, status_o[0]}, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        while (!spi_start_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, spi_start_o}, 32'h1);
    endtask

    initial begin
        int s0, d0, w0, n, bad;
        rst_ni = 1'b0; cmd_we_i = 1'b0; cmd_i = 32'h0;
        spi_done_i = 1'b0; spi_rx_data_i = 8'h00; eng_en = 1'b1; last_tx = 8'h00;
        for (int i = 0; i < 512; i++) begin
            tx_mem[i] = 8'h00;
            rx_mem[i] = 8'hEE;
        end
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'b0, cs_n_o}, 32'h1);
        chk("rst_status", status_o, 32'h0);
        chk("rst_pulses", {29'b0, spi_start_o, rxbuf_we_o, done_o}, 32'h0);
        chk("rst_addr", {14'b0, txbuf_addr_o, rxbuf_addr_o}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Four-byte echo burst
        tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hFF; tx_mem[3] = 8'h01;
        s0 = start_cnt; d0 = done_cnt;
        send(32'h0000_0031);
        chk("b4_busy", {31'b0, status_o[0]}, 32'h1);
        chk("b4_cs_low", {31'b0, cs_n_o}, 32'h0);
        repeat (4) @(negedge clk);
        chk("b4_no_early_start", {31'b0, spi_start_o}, 32'h0);
        @(negedge clk);
        chk("b4_start_latency", {31'b0, spi_start_o}, 32'h1);
        chk("b4_first_tx", {24'b0, spi_tx_data_o}, 32'hA5);
        wait_idle(500, "b4_finish");
        chk("b4_rx0", {24'b0, rx_mem[0]}, 32'hA5);
        chk("b4_rx1", {24'b0, rx_mem[1]}, 32'h3C);
        chk("b4_rx2", {24'b0, rx_mem[2]}, 32'hFF);
        chk("b4_rx3", {24'b0, rx_mem[3]}, 32'h01);
        chk("b4_status", status_o, 32'h0004_0030);
        chk("b4_starts", start_cnt - s0, 4);
        chk("b4_done", done_cnt - d0, 1);
        chk("b4_cs_glitch", cs_glitch, 0);
        chk("b4_cs_high", {31'b0, cs_n_o}, 32'h1);

        // Single byte, both fill flags: all_1s wins
        tx_mem[0] = 8'h12; rx_mem[0] = 8'hEE; s0 = start_cnt;
        send(32'h0000_000D);
        wait_idle(200, "fill_finish");
        chk("fill_tx", {24'b0, last_tx}, 32'hFF);
        chk("fill_rx0", {24'b0, rx_mem[0]}, 32'hFF);
        chk("fill_status", status_o, 32'h0001_000C);
        chk("fill_starts", start_cnt - s0, 1);

        // Two bytes, all_0s only
        tx_mem[0] = 8'h12; tx_mem[1] = 8'h34;
        send(32'h0000_0019);
        wait_idle(200, "zero_finish");
        chk("zero_rx", {16'b0, rx_mem[0], rx_mem[1]}, 32'h0);
        chk("zero_status", status_o, 32'h0002_0018);

        // Engine never answers
        eng_en = 1'b0; w0 = we_cnt; d0 = done_cnt;
        send(32'h0000_0001);
        wait_start(20, "to_start");
        n = 0;
        while (status_o[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 1023);
        chk("to_status", status_o, 32'h0000_0002);
        chk("to_cs_high", {31'b0, cs_n_o}, 32'h1);
        repeat (3) @(negedge clk);
        chk("to_no_we", we_cnt - w0, 0);
        chk("to_no_done", done_cnt - d0, 0);
        eng_en = 1'b1;

        // Abort while waiting on the third byte of an 8-byte burst
        for (int i = 0; i < 8; i++) begin
            tx_mem[i] = 8'h10 + 8'(i);
            rx_mem[i] = 8'hEE;
        end
        w0 = we_cnt; d0 = done_cnt;
        send(32'h0000_0071);
        n = 0;
        while (we_cnt < w0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        wait_start(50, "ab_third_start");
        send(32'h0000_0002);
        chk("ab_cs_high", {31'b0, cs_n_o}, 32'h1);
        chk("ab_status", status_o, 32'h0002_0070);
        repeat (30) @(negedge clk);
        chk("ab_we", we_cnt - w0, 2);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_rx", {8'b0, rx_mem[0], rx_mem[1], rx_mem[2]}, 32'h0010_11EE);
        chk("ab_still_idle", {30'b0, status_o[0], cs_n_o}, 32'h1);

        // Full 512-byte burst with an ignored send while busy
        for (int i = 0; i < 512; i++) begin
            tx_mem[i] = 8'(i) ^ 8'h5A;
            rx_mem[i] = 8'hEE;
        end
        s0 = start_cnt; d0 = done_cnt;
        send(32'h0000_1FF1);
        repeat (3) @(negedge clk);
        send(32'h0000_0031);
        chk("full_n_kept", status_o, 32'h0000_1FF1);
        wait_idle(20000, "full_finish");
        chk("full_status", status_o, 32'h0200_1FF0);
        chk("full_starts", start_cnt - s0, 512);
        chk("full_done", done_cnt - d0, 1);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (rx_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
        end
        chk("full_rx_bad", bad, 0);
        chk("full_last_addr", {7'b0, txbuf_addr_o, 7'b0, rxbuf_addr_o}, 32'h01FF_01FF);

        // Reset in the middle of WAIT, then a fresh burst
        tx_mem[0] = 8'h66;
        send(32'h0000_0031);
        wait_start(20, "rw_start");
        rst_ni = 1'b0;
        #1;
        chk("rw_cs_high", {31'b0, cs_n_o}, 32'h1);
        chk("rw_status", status_o, 32'h0);
        chk("rw_pulses", {29'b0, spi_start_o, rxbuf_we_o, done_o}, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        tx_mem[0] = 8'h77; rx_mem[0] = 8'hEE; d0 = done_cnt;
        send(32'h0000_0001);
        wait_idle(200, "rw_finish");
        chk("rw_rx0", {24'b0, rx_mem[0]}, 32'h77);
        chk("rw_status2", status_o, 32'h0001_0000);
        chk("rw_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
